if_fetch_ctrl: RTL
==================

Name: if_fetch_ctrl

Overview:
Fetch sequencer for the first pipeline stage. It owns the program counter, drives the instruction-memory handshake and assembles 16-bit or 32-bit instructions. Bit 15 of the first word set means a second, immediate word follows. It delivers one complete instruction per valid beat to decode, and handles decode back-pressure and branch redirects.

Parameters:
AW, 16, PC / memory address width
DW, 16, instruction word width
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  in  1  clock, all state updates on posedge
rst_n  in  1  asynchronous active-low reset
mem_addr  out  AW  fetch address, always equal to the internal pc
mem_req  out  1  fetch request (combinational)
mem_rdata  in  DW  fetched word, valid when mem_ready=1
mem_ready  in  1  memory returns mem_rdata for mem_addr this cycle
stall  in  1  decode cannot accept the presented instruction
branch_taken  in  1  redirect request, one-cycle pulse
branch_target  in  AW  redirect address
instr_out  out  DW  opcode word
imm_out  out  DW  immediate word; 16'h0000 for 16-bit instructions
instr_pc  out  AW  address of the opcode word of instr_out
instr_valid  out  1  instr_out/imm_out/instr_pc hold a complete instruction

Behaviour:
- States: OP (fetching opcode word), IMM (fetching immediate word).
- Reset, asynchronous on rst_n low:
  - pc=RESET_PC, state=OP.
  - instr_valid=0; instr_out, imm_out and instr_pc all 0.
  - The first fetch request is issued in the first cycle after release.
- mem_addr=pc. mem_req=!(instr_valid && stall).
- Accept condition: a word is accepted on a posedge where mem_req && mem_ready && !branch_taken.
- OP, word accepted:
  - instr_out<=mem_rdata; instr_pc<=pc; pc<=pc+1.
  - If mem_rdata[15]=0: imm_out<=0, instr_valid<=1, stay OP.
  - If mem_rdata[15]=1: instr_valid<=0, go IMM.
- IMM, word accepted: imm_out<=mem_rdata, instr_valid<=1, pc<=pc+1, go OP.
- No accept and no branch: pc and state hold. instr_valid<=0 unless (instr_valid && stall); in that case all outputs hold unchanged.
- Output beat: consumed on a posedge with instr_valid=1 and stall=0. A new completion in the same cycle replaces it (back-to-back throughput of 1 word/cycle).
- Latency: with zero-wait memory, a 16-bit instruction is valid 1 cycle after its fetch; a 32-bit instruction is valid 2 cycles after its opcode fetch.
- branch_taken has highest priority and overrides stall:
  - pc<=branch_target; state<=OP; instr_valid<=0.
  - Any word returned that cycle is discarded.
  - A half-assembled 32-bit instruction in IMM is dropped.
- pc arithmetic is modulo 2^AW; 16'hFFFF+1 wraps to 16'h0000. A 32-bit instruction at FFFF takes its immediate from 0000.
- Wait states: mem_ready=0 for any number of cycles simply holds state.
- stall while instr_valid=0 has no effect.
- Reset mid-instruction (state IMM) returns to OP at RESET_PC with no output.

Decomposition:
- Shared package/header: state encodings ST_OP=1'b0, ST_IMM=1'b1; LONG_BIT=15; RESET_PC default.
- One natural sub-module, if_out_reg: output holding register (instr/imm/pc/valid with hold-on-stall). The FSM and pc stay in the top.

Test Plan:
- Reset release, memory {0x0012, 0x0034}, mem_ready=1 → mem_addr 0,1,2. instr_valid pulses with (0x0012, imm 0, pc 0) then (0x0034, imm 0, pc 1).
- Memory[4]=0x8005, [5]=0xBEEF, ready=1 → instr_valid low after opcode. Next cycle instr_out=0x8005, imm_out=0xBEEF, instr_pc=4, and pc=6.
- Valid instruction with stall=1 for 3 cycles → outputs frozen, mem_req=0, pc frozen. Stall release → next word fetched and no instruction lost or duplicated.
- In IMM at pc=0x0011, branch_taken=1 with target 0x0100 → instr_valid=0 next cycle, mem_addr=0x0100, no instruction from 0x0010 ever emitted.
- pc=0xFFFF holding 0x8001, [0x0000]=0x1234 → output instr 0x8001, imm 0x1234, instr_pc 0xFFFF, pc then 0x0001.
- mem_ready=0 for 5 cycles mid-IMM, then rst_n low → instr_valid=0 immediately, pc=0x0000 and state OP after release.

Source files
------------

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared constants for the instruction fetch sequencer: FSM encodings,
// the long-instruction flag position and default geometry.
package if_fetch_ctrl_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 16;

    localparam logic [15:0] RESET_PC_DEF = 16'h0000;

    localparam logic [0:0] ST_OP  = 1'b0;
    localparam logic [0:0] ST_IMM = 1'b1;

    localparam int LONG_BIT = 15;

endpackage

// File: rtl/if_fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory handshake, decode-side delivery and
// branch redirect, grouped so the sequencer sees one port.
interface if_fetch_ctrl_if
    import if_fetch_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic [DW-1:0] instr_out;
    logic [DW-1:0] imm_out;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;

    modport master (
        output mem_addr, mem_req, instr_out, imm_out, instr_pc, instr_valid,
        input  mem_rdata, mem_ready, stall, branch_taken, branch_target
    );

    modport slave (
        input  mem_addr, mem_req, instr_out, imm_out, instr_pc, instr_valid,
        output mem_rdata, mem_ready, stall, branch_taken, branch_target
    );
endinterface

// File: rtl/if_fetch_ctrl_out.sv
// Output holding register for the fetch stage: captures opcode/immediate
// words as they complete and freezes a presented instruction while decode stalls.
module if_out_reg
    import if_fetch_ctrl_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          ld_op,
    input  logic          ld_imm,
    input  logic          is_long,
    input  logic          stall,
    input  logic [DW-1:0] word,
    input  logic [AW-1:0] pc,
    output logic [DW-1:0] instr_r,
    output logic [DW-1:0] imm_r,
    output logic [AW-1:0] pc_r,
    output logic          valid_r
);

    // Output register update: redirect drops, loads assemble, idle cycles retire the beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_r <= {DW{1'b0}};
            imm_r   <= {DW{1'b0}};
            pc_r    <= {AW{1'b0}};
            valid_r <= 1'b0;
        end else if (clr) begin
            valid_r <= 1'b0;
        end else if (ld_op) begin
            instr_r <= word;
            pc_r    <= pc;
            if (!is_long) begin
                imm_r <= {DW{1'b0}};
            end
            valid_r <= !is_long;
        end else if (ld_imm) begin
            imm_r   <= word;
            valid_r <= 1'b1;
        end else if (!(valid_r && stall)) begin
            valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: owns the pc, issues memory requests and assembles
// 16/32-bit instructions for decode, honouring stalls and branch redirects.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int          AW       = AW_DEF,
    parameter int          DW       = DW_DEF,
    parameter logic [15:0] RESET_PC = RESET_PC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    if_fetch_ctrl_if.master bus
);

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_nxt_s;
    logic [0:0]    state_r;
    logic [0:0]    state_nxt_s;
    logic          accept_s;
    logic          long_s;
    logic          ld_op_s;
    logic          ld_imm_s;
    logic          mem_req_s;
    logic [DW-1:0] instr_s;
    logic [DW-1:0] imm_s;
    logic [AW-1:0] ipc_s;
    logic          valid_s;

    assign mem_req_s = !(valid_s && bus.stall);
    assign accept_s  = mem_req_s && bus.mem_ready && !bus.branch_taken;
    assign long_s    = bus.mem_rdata[LONG_BIT];

    // Decode which half of an instruction the accepted word completes.
    always_comb begin
        ld_op_s  = 1'b0;
        ld_imm_s = 1'b0;
        case (state_r)
            ST_OP:   ld_op_s  = accept_s;
            ST_IMM:  ld_imm_s = accept_s;
            default: ld_op_s  = 1'b0;
        endcase
    end

    // Next pc/state; a redirect wins over everything, including a returning word.
    always_comb begin
        pc_nxt_s    = pc_r;
        state_nxt_s = state_r;
        if (bus.branch_taken) begin
            pc_nxt_s    = bus.branch_target;
            state_nxt_s = ST_OP;
        end else if (accept_s) begin
            pc_nxt_s = pc_r + PC_ONE;
            case (state_r)
                ST_OP:   state_nxt_s = long_s ? ST_IMM : ST_OP;
                ST_IMM:  state_nxt_s = ST_OP;
                default: state_nxt_s = ST_OP;
            endcase
        end else begin
            pc_nxt_s    = pc_r;
            state_nxt_s = state_r;
        end
    end

    // Program counter and FSM state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r    <= RESET_PC[AW-1:0];
            state_r <= ST_OP;
        end else begin
            pc_r    <= pc_nxt_s;
            state_r <= state_nxt_s;
        end
    end

    if_out_reg #(.AW(AW), .DW(DW)) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (bus.branch_taken),
        .ld_op   (ld_op_s),
        .ld_imm  (ld_imm_s),
        .is_long (long_s),
        .stall   (bus.stall),
        .word    (bus.mem_rdata),
        .pc      (pc_r),
        .instr_r (instr_s),
        .imm_r   (imm_s),
        .pc_r    (ipc_s),
        .valid_r (valid_s)
    );

    assign bus.mem_addr    = pc_r;
    assign bus.mem_req     = mem_req_s;
    assign bus.instr_out   = instr_s;
    assign bus.imm_out     = imm_s;
    assign bus.instr_pc    = ipc_s;
    assign bus.instr_valid = valid_s;

endmodule
